// File: rtl/booth_datapath.sv
// booth_datapath: A/Q/Q-1/M register datapath for a radix-2 Booth signed multiplier.
module booth_datapath #(
    parameter int WIDTH        = 8,
    parameter int COUNTER_BITS = 3
) (
    input  logic                    clk,
    input  logic                    beginsig,
    input  logic                    locksig,
    input  logic [7:0]              control,
    input  logic [WIDTH-1:0]        multiplicand,
    input  logic [WIDTH-1:0]        multiplier,
    output logic [1:0]              q_reg,
    output logic [COUNTER_BITS-1:0] counter_out,
    output logic [WIDTH-1:0]        outbus,
    output logic                    out_valid
);
    logic [WIDTH:0]          a_q, a_d, m_q, m_d, s;
    logic [WIDTH-1:0]        q_q, q_d, out_q, out_d;
    logic                    q1_q, q1_d, valid_q, valid_d;
    logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
    logic                    ctrl_unused;

    assign ctrl_unused = control[7];
    assign s = control[2] ? (control[3] ? a_q - m_q : a_q + m_q) : a_q;

    always_comb begin
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (locksig) begin
            if (control[0]) begin
                a_d   = '0;
                q1_d  = 1'b0;
                cnt_d = '0;
            end else if (control[1]) begin
                m_d = {multiplicand[WIDTH-1], multiplicand};
                q_d = multiplier;
            end else if (control[4]) begin
                {a_d, q_d, q1_d} = {s[WIDTH], s, q_q};
                cnt_d            = cnt_q + COUNTER_BITS'(1);
            end else begin
                a_d = s;
            end
            // output selection reads pre-edge registers, independent of the action above
            out_d   = control[5] ? a_q[WIDTH-1:0] : control[6] ? q_q : out_q;
            valid_d = control[5] | control[6];
        end
    end

    always_ff @(posedge clk) begin
        if (beginsig) begin
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign q_reg       = {q_q[0], q1_q};
    assign counter_out = cnt_q;
    assign outbus      = out_q;
    assign out_valid   = valid_q;
endmodule
